// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues in-order imem requests at pc_in, pairs responses
// with their PCs in a small fetch queue and hands {pc, instr} to decode.
module fetch_unit #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter int FQ_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_enable,
  output logic [XLEN-1:0] next_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] q_pc_r    [FQ_DEPTH];
  logic [ILEN-1:0] q_instr_r [FQ_DEPTH];
  logic [PW-1:0]   q_head_r;
  logic [PW-1:0]   q_tail_r;
  logic [CW-1:0]   q_cnt_r;

  logic [XLEN-1:0] f_pc_r [FQ_DEPTH];
  logic [PW-1:0]   f_head_r;
  logic [PW-1:0]   f_tail_r;
  logic [CW-1:0]   out_cnt_r;
  logic [CW-1:0]   drop_cnt_r;

  logic          pop_s;
  logic          req_fire_s;
  logic          resp_ok_s;
  logic          resp_keep_s;
  logic [CW:0]   used_s;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok_s   = imem_resp_valid & (out_cnt_r != {CW{1'b0}});
  assign resp_keep_s = resp_ok_s & (drop_cnt_r == {CW{1'b0}}) & ~redirect_valid;
  assign pop_s       = id_valid & id_ready;

  // Credits: every outstanding request already owns a queue slot, so the queue cannot overflow.
  assign used_s = {1'b0, out_cnt_r} + {1'b0, q_cnt_r} - {{CW{1'b0}}, pop_s};
  assign imem_req_valid = ~reset & ~redirect_valid & (used_s < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr  = pc_in;
  assign req_fire_s     = imem_req_valid & imem_req_ready;

  assign pc_enable = ~reset & (req_fire_s | redirect_valid);
  assign next_pc   = reset          ? RESET_PC :
                     redirect_valid ? redirect_pc : pc_in + XLEN'(4);

  assign id_valid = (q_cnt_r != {CW{1'b0}});
  assign id_pc    = q_pc_r[q_head_r];
  assign id_instr = q_instr_r[q_head_r];

  // Fetch queue: written from responses, drained by decode, flushed by redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_pc_r[i]    <= {XLEN{1'b0}};
        q_instr_r[i] <= {ILEN{1'b0}};
      end
      q_head_r <= {PW{1'b0}};
      q_tail_r <= {PW{1'b0}};
      q_cnt_r  <= {CW{1'b0}};
    end else if (redirect_valid) begin
      q_head_r <= {PW{1'b0}};
      q_tail_r <= {PW{1'b0}};
      q_cnt_r  <= {CW{1'b0}};
    end else begin
      if (resp_keep_s) begin
        q_pc_r[q_tail_r]    <= f_pc_r[f_head_r];
        q_instr_r[q_tail_r] <= imem_resp_data;
        q_tail_r            <= q_tail_r + PW'(1);
      end
      if (pop_s) begin
        q_head_r <= q_head_r + PW'(1);
      end
      q_cnt_r <= q_cnt_r + CW'(resp_keep_s) - CW'(pop_s);
    end
  end

  // In-flight PC FIFO: one entry per accepted request, survives redirects until answered.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        f_pc_r[i] <= {XLEN{1'b0}};
      end
      f_head_r <= {PW{1'b0}};
      f_tail_r <= {PW{1'b0}};
    end else begin
      if (req_fire_s) begin
        f_pc_r[f_tail_r] <= pc_in;
        f_tail_r         <= f_tail_r + PW'(1);
      end
      if (resp_ok_s) begin
        f_head_r <= f_head_r + PW'(1);
      end
    end
  end

  // Outstanding and drop counters; a redirect marks everything still in flight as stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt_r  <= {CW{1'b0}};
      drop_cnt_r <= {CW{1'b0}};
    end else begin
      out_cnt_r <= out_cnt_r + CW'(req_fire_s) - CW'(resp_ok_s);
      if (redirect_valid) begin
        drop_cnt_r <= out_cnt_r - CW'(resp_ok_s);
      end else if (resp_ok_s && (drop_cnt_r != {CW{1'b0}})) begin
        drop_cnt_r <= drop_cnt_r - CW'(1);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a PC register, an in-order memory with random
// latency and a transaction-level model of what decode must see each cycle.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic [63:0] pc_in;
  logic        pc_enable;
  logic [63:0] next_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;

  fetch_unit #(.XLEN(64), .ILEN(32), .FQ_DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_enable(pc_enable), .next_pc(next_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ep;
    logic [31:0] due;
  } pend_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  pend_t pend[$];   // memory: accepted, unanswered requests
  ent_t  mq[$];     // what decode should currently see, head first
  int    checks;
  int    failures;
  int    cyc;
  int    epoch;
  int    lat_lo;
  int    lat_hi;
  logic [63:0] pc_reg;
  logic [63:0] exp_pc;

  logic        obs_idv;
  logic        obs_rv;
  logic        obs_pen;
  logic [63:0] obs_idpc;
  logic [63:0] obs_addr;
  logic [63:0] obs_npc;

  function automatic logic [31:0] ifunc(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic idr,
                      input logic redir, input logic [63:0] rpc);
    logic  resp_now;
    logic  e_idv;
    logic  e_rv;
    logic  fire;
    logic  pop;
    logic  rd;
    pend_t r;
    pend_t n;
    ent_t  e;
    @(posedge clk);
    #1;
    rd             = redir & ~rst;
    reset          = rst;
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = rd;
    redirect_pc    = rpc;
    pc_in          = pc_reg;
    resp_now       = !rst && (pend.size() > 0) && (int'(pend[0].due) <= cyc);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? ifunc(pend[0].pc) : $urandom;
    @(negedge clk);
    obs_idv  = id_valid;
    obs_rv   = imem_req_valid;
    obs_pen  = pc_enable;
    obs_idpc = id_pc;
    obs_addr = imem_req_addr;
    obs_npc  = next_pc;

    e_idv = (mq.size() > 0);
    pop   = e_idv & idr & ~rst;
    e_rv  = !rst && !rd && ((pend.size() + mq.size() - int'(pop)) < DEPTH);
    fire  = e_rv & rdy;
    if (!rst) begin
      chk("id_valid", {63'h0, id_valid}, {63'h0, e_idv});
      if (e_idv) begin
        chk("id_pc", id_pc, mq[0].pc);
        chk("id_instr", {32'h0, id_instr}, {32'h0, mq[0].ins});
      end
    end
    chk("req_valid", {63'h0, imem_req_valid}, {63'h0, e_rv});
    if (e_rv) chk("req_addr", imem_req_addr, pc_reg);
    chk("pc_enable", {63'h0, pc_enable}, {63'h0, fire | rd});
    chk("next_pc", next_pc, rst ? 64'h0 : (rd ? rpc : pc_reg + 64'd4));

    if (rst) begin
      pend.delete();
      mq.delete();
      epoch++;
      exp_pc = 64'h0;
      pc_reg = 64'h0;
    end else begin
      if (pop) begin
        chk("pop_order", id_pc, exp_pc);
        exp_pc = exp_pc + 64'd4;
        void'(mq.pop_front());
      end
      if (resp_now) begin
        r = pend.pop_front();
        if ((int'(r.ep) == epoch) && !rd) begin
          e.pc  = r.pc;
          e.ins = ifunc(r.pc);
          mq.push_back(e);
        end
      end
      if (rd) begin
        mq.delete();
        epoch++;
        exp_pc = rpc;
      end
      if (fire) begin
        n.pc  = pc_reg;
        n.ep  = 32'(epoch);
        n.due = 32'(cyc + $urandom_range(lat_hi, lat_lo));
        pend.push_back(n);
      end
      pc_reg = rd ? rpc : (fire ? pc_reg + 64'd4 : pc_reg);
    end
    cyc++;
  endtask

  initial begin
    logic [63:0] held;
    logic        found;
    checks = 0; failures = 0; cyc = 0; epoch = 0;
    lat_lo = 1; lat_hi = 1;
    pc_reg = 64'h0; exp_pc = 64'h0;
    reset = 1'b1; pc_in = 64'h0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0; id_ready = 1'b0;

    // Basic streaming: latency 1, decode always ready.
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("t1_reset_npc", obs_npc, 64'h0);
    chk("t1_reset_rv", {63'h0, obs_rv}, 64'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("t1_req0_addr", obs_addr, 64'h0);
    chk("t1_req0_valid", {63'h0, obs_rv}, 64'h1);
    chk("t1_idv_c0", {63'h0, obs_idv}, 64'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("t1_req1_addr", obs_addr, 64'h4);
    chk("t1_idv_c1", {63'h0, obs_idv}, 64'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("t1_idv_c2", {63'h0, obs_idv}, 64'h1);
    chk("t1_idpc_c2", obs_idpc, 64'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("t1_idpc_c3", obs_idpc, 64'h4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("t1_idpc_c4", obs_idpc, 64'h8);

    // Decode stalls for 6 cycles: queue fills, fetch stops, head holds.
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    held = obs_idpc;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("t2_rv_stalled", {63'h0, obs_rv}, 64'h0);
    chk("t2_pen_stalled", {63'h0, obs_pen}, 64'h0);
    chk("t2_head_held", obs_idpc, held);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);

    // Redirect with a request to 0x40 still in flight.
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'h40);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("t3_req_0x40", obs_addr, 64'h40);
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'h100);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("t3_q_empty", {63'h0, obs_idv}, 64'h0);
    chk("t3_req_0x100", obs_addr, 64'h100);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
      found = obs_idv;
    end
    chk("t3_first_pc", found ? obs_idpc : 64'hDEAD, 64'h100);

    // Memory not ready for 4 cycles at 0x20.
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'h20);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
      chk("t4_addr_held", obs_addr, 64'h20);
      chk("t4_pen_low", {63'h0, obs_pen}, 64'h0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("t4_resume_addr", obs_addr, 64'h20);
    chk("t4_resume_pen", {63'h0, obs_pen}, 64'h1);

    // Reset with a full queue.
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("t5_rst_rv", {63'h0, obs_rv}, 64'h0);
    chk("t5_rst_pen", {63'h0, obs_pen}, 64'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("t5_idv_after", {63'h0, obs_idv}, 64'h0);
    chk("t5_restart_addr", obs_addr, 64'h0);

    // PC wrap at the top of the address space.
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("t6_addr", obs_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_npc_wrap", obs_npc, 64'h0);
    chk("t6_pen", {63'h0, obs_pen}, 64'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rpc;
      if (i % 200 == 0) lat_hi = $urandom_range(4, 1);
      rpc = ($urandom % 4 == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom} & ~64'h3;
      step(($urandom % 300) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
           ($urandom % 25) == 0, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
